// File: rtl/tt_counter_pkg.sv
// Shared constants for the tt_um_counter tile: widths and ui_in control bit positions.
package tt_counter_pkg;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned PRE_W = 3;

    localparam int unsigned CNT_EN   = 0;
    localparam int unsigned DIR      = 1;
    localparam int unsigned LOAD     = 2;
    localparam int unsigned CLR      = 3;
    localparam int unsigned PSEL_LSB = 4;
    localparam int unsigned SAT      = 6;

endpackage

// File: rtl/counter_prescaler.sv
// Programmable divide-by-1/2/4/8 prescaler; tick is combinational so the
// counter steps on the same edge that the prescaler wraps.
module counter_prescaler
    import tt_counter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    input  logic [1:0] sel,
    output logic       tick
);

    logic [PRE_W-1:0] presc_q;
    logic [PRE_W-1:0] presc_d;
    logic [PRE_W-1:0] mask;
    logic             match;

    always_comb begin
        unique case (sel)
            2'd0:    mask = 3'b000;
            2'd1:    mask = 3'b001;
            2'd2:    mask = 3'b011;
            default: mask = 3'b111;
        endcase
    end

    // Masked compare lets presc_sel change mid-run without a prescaler reset.
    assign match = (presc_q & mask) == mask;
    assign tick  = en & match;

    always_comb begin
        presc_d = presc_q;
        if (clr) begin
            presc_d = '0;
        end else if (en) begin
            presc_d = match ? '0 : presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/tt_um_counter.sv
// Tiny Tapeout tile: 8-bit up/down counter with clear, load, prescaler and
// wrap/saturate modes. Bidirectional pins are used only as load-data inputs.
module tt_um_counter
    import tt_counter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             clr;
    logic             load;
    logic             cnt_en;
    logic             presc_en;
    logic             presc_clr;
    logic             tick;
    logic             at_max;
    logic             at_min;

    wire unused = &{1'b0, ui_in[7], 1'b0};

    assign clr    = ui_in[CLR];
    assign load   = ui_in[LOAD];
    assign cnt_en = ui_in[CNT_EN];

    // ena gates every prescaler update so a deselected tile fully freezes.
    assign presc_clr = ena & (clr | load);
    assign presc_en  = ena & cnt_en & ~clr & ~load;

    counter_prescaler u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (presc_en),
        .clr   (presc_clr),
        .sel   (ui_in[PSEL_LSB+1:PSEL_LSB]),
        .tick  (tick)
    );

    assign at_max = count_q == {WIDTH{1'b1}};
    assign at_min = count_q == '0;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = uio_in;
        end else if (tick) begin
            if (ui_in[DIR]) begin
                if (!(ui_in[SAT] && at_max)) count_d = count_q + 1'b1;
            end else begin
                if (!(ui_in[SAT] && at_min)) count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (ena) begin
            count_q <= count_d;
        end
    end

    assign uo_out  = count_q;
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_counter.sv
// Directed self-checking bench for tt_um_counter with hand-computed expectations.
module tb_tt_um_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int errors = 0;
    int checks = 0;

    tt_um_counter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    // Advance n rising edges; inputs change and outputs are sampled 1ns after the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h01;
        uio_in = 8'h00;
        #1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("reset_hold", uo_out, 8'h00);
        end
        check("uio_oe", uio_oe, 8'h00);
        check("uio_out", uio_out, 8'h00);
        rst_n = 1'b1;

        // Up count /1 then down.
        ui_in = 8'h03;
        step(1);
        check("up_first", uo_out, 8'h01);
        step(9);
        check("up_10", uo_out, 8'd10);
        ui_in = 8'h01;
        step(3);
        check("down_7", uo_out, 8'd7);

        // Load and wrap.
        uio_in = 8'hFE;
        ui_in  = 8'h04;
        step(1);
        check("load_fe", uo_out, 8'hFE);
        ui_in = 8'h03;
        step(1);
        check("wrap_ff", uo_out, 8'hFF);
        step(1);
        check("wrap_00", uo_out, 8'h00);
        step(1);
        check("wrap_01", uo_out, 8'h01);
        uio_in = 8'h00;
        ui_in  = 8'h04;
        step(1);
        ui_in = 8'h01;
        step(1);
        check("wrap_down_ff", uo_out, 8'hFF);

        // Saturate up then down.
        uio_in = 8'hFD;
        ui_in  = 8'h04;
        step(1);
        ui_in = 8'h43;
        step(1);
        check("sat_up_fe", uo_out, 8'hFE);
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("sat_up_ff", uo_out, 8'hFF);
        end
        uio_in = 8'h01;
        ui_in  = 8'h04;
        step(1);
        ui_in = 8'h41;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("sat_down_00", uo_out, 8'h00);
        end

        // Prescaler /8.
        ui_in = 8'h08;
        step(1);
        check("clear", uo_out, 8'h00);
        ui_in = 8'h33;
        step(7);
        check("div8_c7", uo_out, 8'd0);
        step(1);
        check("div8_c8", uo_out, 8'd1);
        step(7);
        check("div8_c15", uo_out, 8'd1);
        step(1);
        check("div8_c16", uo_out, 8'd2);
        step(8);
        check("div8_c24", uo_out, 8'd3);

        // ena=0 must also freeze the prescaler (/2: phase is preserved across 3 idle edges).
        ui_in = 8'h08;
        step(1);
        ui_in = 8'h13;
        step(1);
        check("div2_c1", uo_out, 8'd0);
        ena = 1'b0;
        step(3);
        ena = 1'b1;
        step(1);
        check("div2_frozen_phase", uo_out, 8'd1);

        // Priority and gating.
        uio_in = 8'h55;
        ui_in  = 8'h0F;
        step(1);
        check("clr_wins", uo_out, 8'h00);
        ui_in = 8'h07;
        step(1);
        check("load_wins", uo_out, 8'h55);
        ena   = 1'b0;
        ui_in = 8'h03;
        step(10);
        check("ena_freeze", uo_out, 8'h55);
        ena = 1'b1;
        step(2);
        check("resume", uo_out, 8'h57);

        // Asynchronous reset mid-count.
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset", uo_out, 8'h00);
        #1;
        rst_n = 1'b1;
        step(1);
        check("after_reset", uo_out, 8'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tt_um_counter.md
Name: tt_um_counter

Overview:
- Tiny Tapeout user tile implementing an 8-bit programmable up/down counter.
- Features: count enable, direction control, synchronous clear and parallel load, selectable prescaler (÷1/2/4/8) and wrap/saturate mode.
- Count value drives the dedicated outputs; load data arrives on the bidirectional pins, which are used as inputs only.
- Top-level tile, instantiated directly by the chip harness.

Parameters:
- WIDTH, 8, counter width; fixed by the 8-bit pin groups and not to be overridden.
- PRE_W, 3, prescaler register width; supports divide ratios up to 8.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- ena  input  1  tile select; when low, all state holds (no count, no load, no clear).
- ui_in  input  8  controls: [0] cnt_en, [1] dir (1=up, 0=down), [2] load, [3] clear, [5:4] presc_sel, [6] sat_mode (1=saturate, 0=wrap), [7] unused.
- uo_out  output  8  current count value.
- uio_in  input  8  parallel load value.
- uio_out  output  8  tied to 8'h00.
- uio_oe  output  8  tied to 8'h00 (all bidirectional pins are inputs).

Behaviour:
- Reset (rst_n=0, asynchronous): count=0 and prescaler=0, so uo_out=0x00 immediately. uio_out and uio_oe are always 0.
- All other updates are synchronous and occur only when ena=1. Priority on each edge is clear > load > count.
- Clear (ui_in[3]=1): count<=0, prescaler<=0.
- Load (ui_in[2]=1, clear=0): count<=uio_in, prescaler<=0. The loaded value appears on uo_out the cycle after the edge.
- Prescaler:
  - mask = (1<<presc_sel)-1, giving 0/1/3/7.
  - While cnt_en=1 and no clear/load: if (presc & mask)==mask, tick=1 and presc<=0; otherwise presc<=presc+1 and tick=0.
  - presc_sel=0 ticks every cycle. presc_sel=3 ticks on every 8th enabled cycle.
  - When cnt_en=0, the prescaler holds its value.
- Count step, on tick:
  - dir=1: count+1. dir=0: count-1.
  - Wrap mode: 0xFF+1 -> 0x00; 0x00-1 -> 0xFF.
  - Saturate mode: stays at 0xFF going up; stays at 0x00 going down. The prescaler still advances and resets normally.
- uo_out is registered (equals count). The first increment is visible one cycle after cnt_en rises with presc_sel=0.
- Changing presc_sel mid-run takes effect on the next compare; no reset of the prescaler is required.
- Changing dir mid-run takes effect on the next tick.
- ena=0 freezes count and prescaler regardless of ui_in.
- Reset asserted mid-operation clears everything immediately. Counting resumes on the first edge after rst_n deasserts, if enabled.
- ui_in[7] is ignored. The unused ena/ui_in bits must not cause lint warnings; reduce them into a dummy wire.

Decomposition:
- Shared package tt_counter_pkg holds:
  - the WIDTH and PRE_W constants;
  - bit-index localparams for the ui_in fields (CNT_EN=0, DIR=1, LOAD=2, CLR=3, PSEL_LSB=4, SAT=6).
- One sub-module, counter_prescaler (PRE_W-bit divider with enable, sync clear and tick output), instantiated by tt_um_counter.
- The count register and the wrap/saturate logic stay in the top level.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles while ui_in=0x01 -> uo_out=0x00 throughout; uio_oe=0x00 and uio_out=0x00.
- Up count ÷1: ena=1, ui_in=0x03 for 10 cycles after reset -> uo_out=10. Then ui_in=0x01 (down) for 3 cycles -> uo_out=7.
- Load and wrap:
  - uio_in=0xFE, pulse ui_in=0x04 for 1 cycle -> uo_out=0xFE.
  - Then ui_in=0x03 for 3 cycles -> 0xFF, 0x00, 0x01.
  - Load 0x00 and count down one cycle -> 0xFF.
- Saturate:
  - Load 0xFD, then ui_in=0x43 for 5 cycles -> 0xFE, 0xFF, 0xFF, 0xFF, 0xFF.
  - Load 0x01, then ui_in=0x41 for 3 cycles -> 0x00, 0x00, 0x00.
- Prescaler: clear, then ui_in=0x33 (÷8) for 24 cycles -> uo_out=3; increments land on cycles 8, 16 and 24 after enable.
- Priority and gating:
  - ui_in=0x0F with uio_in=0x55 -> uo_out=0x00 (clear wins over load and count).
  - ui_in=0x07 -> 0x55 (load wins over count).
  - ena=0 with ui_in=0x03 for 10 cycles -> value unchanged.
  - rst_n pulsed low mid-count -> 0x00 immediately.
